// File: rtl/jtag_dr_ir_regs_if.sv
// TAP-side strobe/serial bundle between the TAP state machine and the
// instruction/data register stage.
interface jtag_dr_ir_regs_if;
  logic tdi;
  logic cdr1, sdr1, udr1;
  logic cir1, sir1, uir1;
  logic tdo;
  logic tdo_en;

  // TAP controller side: drives strobes and serial input.
  modport master (
    output tdi, cdr1, sdr1, udr1, cir1, sir1, uir1,
    input  tdo, tdo_en
  );

  // Register stage side.
  modport slave (
    input  tdi, cdr1, sdr1, udr1, cir1, sir1, uir1,
    output tdo, tdo_en
  );
endinterface

// File: rtl/jtag_dr_ir_regs.sv
// JTAG instruction register plus BYPASS / IDCODE / USER data registers.
// Sits directly behind the TAP FSM and consumes its decoded strobes.
module jtag_dr_ir_regs #(
  parameter int                IR_W       = 4,
  parameter int                DR_W       = 8,
  parameter logic [31:0]       IDCODE_VAL = 32'h1234_5A5B,
  parameter logic [IR_W-1:0]   OP_IDCODE  = IR_W'(1),
  parameter logic [IR_W-1:0]   OP_USER    = IR_W'(2)
) (
  input  logic                 tck,
  input  logic                 trst,
  jtag_dr_ir_regs_if.slave     tap,
  input  logic [DR_W-1:0]      user_in,
  output logic [IR_W-1:0]      ir_q,
  output logic [DR_W-1:0]      user_out,
  output logic                 user_upd
);

  typedef enum logic [1:0] {
    SEL_BYP = 2'd0,
    SEL_ID  = 2'd1,
    SEL_USR = 2'd2
  } sel_e;

  logic [IR_W-1:0] ir_sr_q, ir_sr_d;
  logic [IR_W-1:0] ir_d;
  logic            byp_sr_q, byp_sr_d;
  logic [31:0]     id_sr_q, id_sr_d;
  logic [DR_W-1:0] usr_sr_q, usr_sr_d;
  logic [DR_W-1:0] user_out_q, user_out_d;
  logic            user_upd_q, user_upd_d;
  logic [DR_W-1:0] usr_shift;
  logic [IR_W-1:0] ir_shift;
  sel_e            sel;

  // DR select from the active instruction; BYPASS covers all-ones and
  // every unassigned code.
  always_comb begin
    sel = SEL_BYP;
    if (ir_q == OP_IDCODE)    sel = SEL_ID;
    else if (ir_q == OP_USER) sel = SEL_USR;
  end

  // Right-shift helpers written width-agnostic so DR_W = 1 still works.
  always_comb begin
    usr_shift           = usr_sr_q >> 1;
    usr_shift[DR_W-1]   = tap.tdi;
    ir_shift            = ir_sr_q >> 1;
    ir_shift[IR_W-1]    = tap.tdi;
  end

  // Next-state: capture > shift > update, independently for IR and DR paths.
  always_comb begin
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    byp_sr_d   = byp_sr_q;
    id_sr_d    = id_sr_q;
    usr_sr_d   = usr_sr_q;
    user_out_d = user_out_q;
    user_upd_d = 1'b0;

    if (tap.cir1)      ir_sr_d = IR_W'(2'b01);
    else if (tap.sir1) ir_sr_d = ir_shift;
    else if (tap.uir1) ir_d    = ir_sr_q;

    unique case (sel)
      SEL_ID: begin
        if (tap.cdr1)      id_sr_d = IDCODE_VAL;
        else if (tap.sdr1) id_sr_d = {tap.tdi, id_sr_q[31:1]};
      end
      SEL_USR: begin
        if (tap.cdr1)      usr_sr_d = user_in;
        else if (tap.sdr1) usr_sr_d = usr_shift;
        else if (tap.udr1) begin
          user_out_d = usr_sr_q;
          user_upd_d = 1'b1;
        end
      end
      default: begin
        if (tap.cdr1)      byp_sr_d = 1'b0;
        else if (tap.sdr1) byp_sr_d = tap.tdi;
      end
    endcase
  end

  // State registers with synchronous reset; strobes in a reset cycle are dropped.
  always_ff @(posedge tck) begin
    if (trst) begin
      ir_sr_q    <= IR_W'(2'b01);
      ir_q       <= OP_IDCODE;
      byp_sr_q   <= 1'b0;
      id_sr_q    <= IDCODE_VAL;
      usr_sr_q   <= '0;
      user_out_q <= '0;
      user_upd_q <= 1'b0;
    end else begin
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      byp_sr_q   <= byp_sr_d;
      id_sr_q    <= id_sr_d;
      usr_sr_q   <= usr_sr_d;
      user_out_q <= user_out_d;
      user_upd_q <= user_upd_d;
    end
  end

  // Serial output mux: IR path while shifting IR, else selected DR LSB.
  always_comb begin
    tap.tdo = byp_sr_q;
    if (tap.sir1) tap.tdo = ir_sr_q[0];
    else begin
      unique case (sel)
        SEL_ID:  tap.tdo = id_sr_q[0];
        SEL_USR: tap.tdo = usr_sr_q[0];
        default: tap.tdo = byp_sr_q;
      endcase
    end
    tap.tdo_en = tap.sir1 | tap.sdr1;
  end

  assign user_out = user_out_q;
  assign user_upd = user_upd_q;

endmodule

// File: tb/tb_jtag_dr_ir_regs.sv
// Directed bench for jtag_dr_ir_regs with hand-computed expectations.
module tb_jtag_dr_ir_regs;
  logic       tck = 1'b0;
  logic       trst;
  logic [7:0] user_in;
  logic [3:0] ir_q;
  logic [7:0] user_out;
  logic       user_upd;

  int n_chk = 0;
  int n_err = 0;
  logic obs_tdo, obs_en;

  // strobe order {cdr1, sdr1, udr1, cir1, sir1, uir1}
  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_CDR  = 6'b100000;
  localparam logic [5:0] S_SDR  = 6'b010000;
  localparam logic [5:0] S_UDR  = 6'b001000;
  localparam logic [5:0] S_CIR  = 6'b000100;
  localparam logic [5:0] S_SIR  = 6'b000010;
  localparam logic [5:0] S_UIR  = 6'b000001;

  jtag_dr_ir_regs_if tap ();

  jtag_dr_ir_regs dut (
    .tck      (tck),
    .trst     (trst),
    .tap      (tap),
    .user_in  (user_in),
    .ir_q     (ir_q),
    .user_out (user_out),
    .user_upd (user_upd)
  );

  always #5 tck = ~tck;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: drive strobes, sample tdo mid-cycle, return 1 after the edge.
  task automatic cyc(input logic [5:0] st, input logic d);
    {tap.cdr1, tap.sdr1, tap.udr1, tap.cir1, tap.sir1, tap.uir1} = st;
    tap.tdi = d;
    @(negedge tck);
    obs_tdo = tap.tdo;
    obs_en  = tap.tdo_en;
    @(posedge tck);
    #1;
    {tap.cdr1, tap.sdr1, tap.udr1, tap.cir1, tap.sir1, tap.uir1} = S_IDLE;
    tap.tdi = 1'b0;
  endtask

  task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
    cyc(S_CIR, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(S_SIR, op[i]);
      cap[i] = obs_tdo;
    end
    cyc(S_UIR, 1'b0);
  endtask

  initial begin
    logic [31:0] v32;
    logic [7:0]  v8;
    logic [4:0]  v5;
    logic [3:0]  v4;
    logic [4:0]  byp_in;
    logic [7:0]  usr_bits;
    logic [3:0]  ops [2];
    int en_cnt;

    trst    = 1'b1;
    user_in = 8'h00;
    {tap.cdr1, tap.sdr1, tap.udr1, tap.cir1, tap.sir1, tap.uir1} = S_IDLE;
    tap.tdi = 1'b0;
    repeat (2) @(posedge tck);
    #1;
    trst = 1'b0;

    // reset state
    chk("rst_ir_q", 64'(ir_q), 64'h1);
    chk("rst_user_out", 64'(user_out), 64'h0);
    chk("rst_user_upd", 64'(user_upd), 64'h0);
    #1;
    chk("rst_tdo", 64'(tap.tdo), 64'h1);
    chk("rst_tdo_en", 64'(tap.tdo_en), 64'h0);

    // IDCODE read
    en_cnt = 0;
    cyc(S_CDR, 1'b0);
    if (obs_en) en_cnt++;
    for (int i = 0; i < 32; i++) begin
      cyc(S_SDR, 1'b0);
      v32[i] = obs_tdo;
      if (obs_en) en_cnt++;
    end
    cyc(S_IDLE, 1'b0);
    if (obs_en) en_cnt++;
    chk("idcode_tdo", 64'(v32), 64'h1234_5A5B);
    chk("idcode_en_cnt", 64'(en_cnt), 64'd32);

    // IR load, capture pattern 01 visible on tdo
    load_ir(4'h2, v4);
    chk("ir_capture", 64'(v4), 64'h1);
    chk("ir_user", 64'(ir_q), 64'h2);

    // USER round trip
    user_in  = 8'hA5;
    usr_bits = 8'h3C;
    cyc(S_CDR, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(S_SDR, usr_bits[i]);
      v8[i] = obs_tdo;
    end
    chk("user_tdo", 64'(v8), 64'hA5);
    chk("user_upd_pre", 64'(user_upd), 64'h0);
    cyc(S_UDR, 1'b0);
    chk("user_out", 64'(user_out), 64'h3C);
    chk("user_upd_pulse", 64'(user_upd), 64'h1);
    cyc(S_IDLE, 1'b0);
    chk("user_upd_single", 64'(user_upd), 64'h0);

    // BYPASS (all-ones) and an unassigned opcode
    ops[0] = 4'hF;
    ops[1] = 4'h7;
    byp_in = 5'b01101; // tdi 1,0,1,1,0 LSB first
    for (int k = 0; k < 2; k++) begin
      load_ir(ops[k], v4);
      chk("byp_ir_q", 64'(ir_q), 64'(ops[k]));
      cyc(S_CDR, 1'b0);
      for (int i = 0; i < 5; i++) begin
        cyc(S_SDR, byp_in[i]);
        v5[i] = obs_tdo;
      end
      chk("byp_tdo", 64'(v5), 64'(5'b11010)); // tdo 0,1,0,1,1
      cyc(S_UDR, 1'b0);
      chk("byp_user_out", 64'(user_out), 64'h3C);
      chk("byp_no_upd", 64'(user_upd), 64'h0);
    end

    // Reset in the middle of a USER shift
    load_ir(4'h2, v4);
    user_in = 8'hA5;
    cyc(S_CDR, 1'b0);
    for (int i = 0; i < 3; i++) cyc(S_SDR, 1'b1);
    trst = 1'b1;
    cyc(S_SDR, 1'b1);
    trst = 1'b0;
    chk("mid_ir_q", 64'(ir_q), 64'h1);
    chk("mid_usr_sr", 64'(dut.usr_sr_q), 64'h0);
    chk("mid_user_out", 64'(user_out), 64'h0);
    chk("mid_user_upd", 64'(user_upd), 64'h0);
    cyc(S_IDLE, 1'b0);
    chk("mid_user_upd_next", 64'(user_upd), 64'h0);
    chk("mid_tdo", 64'(obs_tdo), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/jtag_dr_ir_regs.md
# jtag_dr_ir_regs

Register stage directly downstream of the TAP state machine. Consumes the decoded capture/shift/update strobes (`cdr1`, `sdr1`, `udr1`, `cir1`, `sir1`, `uir1`) and implements the JTAG instruction register plus three data registers: BYPASS, IDCODE and USER. Drives `tdo` from the selected shift path. The USER register's parallel in/out ports connect to core logic.

## Interface
- `IR_W`, 4: instruction register width, minimum 2.
- `DR_W`, 8: USER data register width, minimum 1.
- `IDCODE_VAL`, 32'h1234_5A5B: IDCODE capture value; bit 0 must be 1.
- `OP_IDCODE`, 4'h1: IDCODE opcode.
- `OP_USER`, 4'h2: USER opcode.
- BYPASS opcode is fixed at all-ones.
- `tck`  in  1  sole clock; all state changes on its rising edge.
- `trst`  in  1  reset, **synchronous, active-high**.
- `tdi`  in  1  serial data in.
- `cdr1`, `sdr1`, `udr1`  in  1 each  TAP in CAPTURE_DR / SHIFT_DR / UPDATE_DR.
- `cir1`, `sir1`, `uir1`  in  1 each  TAP in CAPTURE_IR / SHIFT_IR / UPDATE_IR.
- `user_in`  in  DR_W  parallel value captured into the USER path.
- `tdo`  out  1  serial data out.
- `tdo_en`  out  1  high while shifting.
- `ir_q`  out  IR_W  active instruction.
- `user_out`  out  DR_W  USER update register.
- `user_upd`  out  1  one-cycle pulse when `user_out` loads.

## Operation
- **Registers**
  - `ir_sr` (IR_W), `ir_q` (IR_W).
  - `byp_sr` (1), `id_sr` (32), `usr_sr` (DR_W).
  - `user_out` (DR_W), `user_upd`.
- **Select decode from `ir_q`**
  - `OP_IDCODE` → IDCODE.
  - `OP_USER` → USER.
  - All-ones → BYPASS.
  - Any other code → BYPASS.
- **IR path**
  - `cir1`: `ir_sr` <= {zeros, 2'b01}.
  - `sir1`: `ir_sr` <= {`tdi`, `ir_sr`[IR_W-1:1]}.
  - `uir1`: `ir_q` <= `ir_sr`.
- **DR path** (only the selected register acts; the others hold)
  - BYPASS: `cdr1` loads 0; `sdr1` loads `tdi`.
  - IDCODE: `cdr1` loads `IDCODE_VAL`; `sdr1` shifts right with `tdi` into the MSB.
  - USER: `cdr1` loads `user_in`; `sdr1` shifts right with `tdi` into the MSB.
  - USER + `udr1`: `user_out` <= `usr_sr`, and `user_upd` = 1 for the following cycle.
  - `udr1` with BYPASS or IDCODE selected changes nothing.
- **Output mux** (combinational)
  - `tdo` = `ir_sr`[0] when `sir1`.
  - Otherwise `tdo` = LSB of the selected DR shift register.
  - `tdo_en` = `sir1` | `sdr1`.
- **Strobe priority**
  - The strobes are mutually exclusive in normal use.
  - If several are asserted together, priority is `trst` > capture > shift > update, within the IR path and within the DR path.
  - The IR and DR paths act independently of each other.
- **Instruction switching**
  - A change of `ir_q` takes effect for DR selection on the cycle after the update edge.
  - No DR shift register is cleared on an instruction change.

## Timing
- **Reset** (`trst` high at a rising edge)
  - `ir_sr` = {zeros, 01}.
  - `ir_q` = `OP_IDCODE`.
  - `byp_sr` = 0, `id_sr` = `IDCODE_VAL`, `usr_sr` = 0.
  - `user_out` = 0, `user_upd` = 0.
  - Consequently `tdo` = 1 (IDCODE bit 0) and `tdo_en` = 0.
- **Reset mid-operation:** a shift or update in progress is aborted. Strobes asserted in the same cycle as `trst` are ignored.
- Capture, shift and update each take effect at the rising edge that ends the cycle in which the strobe is high.
- **`tdo` timing**
  - `tdo` shows the shift register LSB in the same cycle, before the shift edge.
  - Bit k of a captured value appears on `tdo` during the (k+1)-th `sdr1` cycle.
- **BYPASS** delays `tdo` by one `sdr1` cycle relative to `tdi`.
- **Shift length is unbounded:** past the register width, `tdi` values continue to fall through.
- **`user_upd`** is registered: high exactly one cycle after the `udr1` edge, and never high for two consecutive cycles from a single update.

## Test plan
- **Reset:** assert `trst` for 2 cycles → `ir_q` = 4'h1, `user_out` = 0, `user_upd` = 0, `tdo` = 1, `tdo_en` = 0.
- **IDCODE read:** after reset, one `cdr1` then 32 `sdr1` with `tdi` = 0 → `tdo` sequence LSB-first equals 32'h1234_5A5B. `tdo_en` is high for exactly those 32 cycles.
- **IR load and capture pattern**
  - `cir1`, then 4 `sir1` with `tdi` = 0,1,0,0 (LSB first), then `uir1` → `tdo` during the shift = 1,0,0,0 and `ir_q` = 4'h2.
- **USER round trip:** with `ir_q` = 4'h2 and `user_in` = 8'hA5, run `cdr1`, then 8 `sdr1` with `tdi` bits of 8'h3C LSB-first, then `udr1`.
  - `tdo` = bits of 8'hA5 LSB-first.
  - `user_out` = 8'h3C.
  - `user_upd` pulses for 1 cycle.
- **BYPASS and illegal opcode:** load `ir_q` = 4'hF, then separately 4'h7. For each, `cdr1` then 5 `sdr1` with `tdi` = 1,0,1,1,0 → `tdo` = 0,1,0,1,1. `udr1` leaves `user_out` unchanged.
- **Reset mid-shift:** during the 4th `sdr1` of a USER shift, assert `trst` → the next cycle shows `ir_q` = 4'h1, `usr_sr` = 0, `user_out` = 0 and no `user_upd` pulse.
